// File: rtl/pwm_scaler_pkg.sv
// Shared constants and the config pair type for the programmable PWM/clock scaler.
// The reset defaults give 3.125 MHz at 50 % duty from clk_50M.
package pwm_scaler_pkg;

    localparam int PKG_DIV_W          = 16;
    localparam int MIN_PERIOD         = 2;
    localparam int PKG_DEFAULT_PERIOD = 16;
    localparam int PKG_DEFAULT_HIGH   = 8;

    typedef struct packed {
        logic [PKG_DIV_W-1:0] period;
        logic [PKG_DIV_W-1:0] high;
    } cfg_pair_t;

endpackage

// File: rtl/period_counter.sv
// Free-running 0..period-1 counter that flags the last cycle of each period.
// The wrap flag is only raised while running, so a held counter never reloads config.
module period_counter #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    output logic [DIV_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = enable && (cnt == period - DIV_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= wrap ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_frequency_scaler.sv
// Runtime-programmable divided clock / PWM generator with a period-start tick.
// New settings are held in a shadow pair and only become active at a period boundary.
module pwm_frequency_scaler
    import pwm_scaler_pkg::*;
#(
    parameter int DIV_W          = PKG_DIV_W,
    parameter int DEFAULT_PERIOD = PKG_DEFAULT_PERIOD,
    parameter int DEFAULT_HIGH   = PKG_DEFAULT_HIGH
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic [DIV_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             period_tick,
    output logic             cfg_pending
);

    typedef struct packed {
        logic [DIV_W-1:0] period;
        logic [DIV_W-1:0] high;
    } cfg_t;

    localparam logic [DIV_W-1:0] MIN_P = DIV_W'(MIN_PERIOD);
    localparam logic [DIV_W-1:0] DEF_P = DIV_W'(DEFAULT_PERIOD);
    localparam logic [DIV_W-1:0] DEF_H = DIV_W'(DEFAULT_HIGH);

    cfg_t             active;
    cfg_t             shadow;
    cfg_t             incoming;
    logic [DIV_W-1:0] cnt;
    logic             wrap;

    // A period below two cycles cannot produce a waveform, so requests are raised to the minimum.
    always_comb begin
        incoming.period = (cfg_period < MIN_P) ? MIN_P : cfg_period;
        incoming.high   = cfg_high;
    end

    period_counter #(
        .DIV_W (DIV_W)
    ) u_counter (
        .clk    (clk_50M),
        .reset  (reset),
        .enable (enable),
        .clear  (~enable),
        .period (active.period),
        .cnt    (cnt),
        .wrap   (wrap)
    );

    // Config may only change while idle or on the wrap edge; a load on the wrap edge wins over the shadow.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            active      <= '{period: DEF_P, high: DEF_H};
            shadow      <= '{period: DEF_P, high: DEF_H};
            cfg_pending <= 1'b0;
            clk_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            clk_out     <= enable && (cnt < active.high);
            period_tick <= enable && (cnt == '0);
            if (!enable || wrap) begin
                if (cfg_load) begin
                    active      <= incoming;
                    shadow      <= incoming;
                    cfg_pending <= 1'b0;
                end else if (cfg_pending) begin
                    active      <= shadow;
                    cfg_pending <= 1'b0;
                end
            end else if (cfg_load) begin
                shadow      <= incoming;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_frequency_scaler.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a position-in-period model,
// and a separate monitor compares them against the DUT one step after every rising edge.
module tb_pwm_frequency_scaler;
    import pwm_scaler_pkg::*;

    typedef struct {
        logic clk_out;
        logic tick;
        logic pending;
    } exp_t;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_load;
    logic [15:0] cfg_period;
    logic [15:0] cfg_high;
    logic        clk_out;
    logic        period_tick;
    logic        cfg_pending;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    cfg_pair_t act_cfg;
    cfg_pair_t shd_cfg;
    bit        shd_valid;
    int        pos;

    pwm_frequency_scaler #(
        .DIV_W          (16),
        .DEFAULT_PERIOD (16),
        .DEFAULT_HIGH   (8)
    ) dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .cfg_pending (cfg_pending)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        act_cfg   = '{period: 16'd16, high: 16'd8};
        shd_cfg   = act_cfg;
        shd_valid = 0;
        pos       = 0;
    endtask

    // One clock of stimulus; the model predicts what the DUT shows after the coming rising edge.
    task automatic applyStimulus(input bit en, input bit ld, input int p, input int h);
        cfg_pair_t req;
        exp_t      e;
        int        period_len;
        @(negedge clk_50M);
        enable     = en;
        cfg_load   = ld;
        cfg_period = 16'(p);
        cfg_high   = 16'(h);
        req.period = (p < 2) ? 16'd2 : 16'(p);
        req.high   = 16'(h);
        period_len = int'(act_cfg.period);
        e.clk_out  = en && (pos < int'(act_cfg.high));
        e.tick     = en && (pos == 0);
        if (!en || pos == period_len - 1) begin
            if (ld) begin
                act_cfg = req;
            end else if (shd_valid) begin
                act_cfg = shd_cfg;
            end
            shd_valid = 0;
            pos = 0;
        end else begin
            pos++;
            if (ld) begin
                shd_cfg   = req;
                shd_valid = 1;
            end
        end
        e.pending = shd_valid;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1, 0, 0, 0);
    endtask

    task automatic waitPos(input int target);
        int guard = 0;
        while (pos != target && guard < 200) begin
            applyStimulus(1, 0, 0, 0);
            guard++;
        end
        if (guard >= 200) checkOutput("wait_pos", pos, target);
    endtask

    always @(posedge clk_50M) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("clk_out", int'(clk_out), int'(e.clk_out));
            checkOutput("period_tick", int'(period_tick), int'(e.tick));
            checkOutput("cfg_pending", int'(cfg_pending), int'(e.pending));
        end
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        cfg_load   = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        modelReset();
        #3;
        checkOutput("reset_clk_out", int'(clk_out), 0);
        checkOutput("reset_tick", int'(period_tick), 0);
        checkOutput("reset_pending", int'(cfg_pending), 0);
        @(negedge clk_50M);
        reset = 1'b0;

        $display("[TB] defaults 16/8");
        idle(40);

        $display("[TB] shadowed load 10/3 mid-period");
        waitPos(5);
        applyStimulus(1, 1, 10, 3);
        idle(30);

        $display("[TB] duty boundaries high=0 and high=20");
        applyStimulus(1, 1, 10, 0);
        idle(25);
        applyStimulus(1, 1, 10, 20);
        idle(25);

        $display("[TB] clamped periods and load on the wrap edge");
        applyStimulus(1, 1, 0, 1);
        idle(12);
        applyStimulus(1, 1, 1, 1);
        idle(8);
        applyStimulus(1, 1, 9, 4);
        idle(12);
        waitPos(8);
        applyStimulus(1, 1, 5, 2);
        idle(12);

        $display("[TB] repeated load, last value wins");
        waitPos(1);
        applyStimulus(1, 1, 7, 1);
        applyStimulus(1, 1, 6, 3);
        idle(15);

        $display("[TB] enable drop mid-high and re-enable");
        waitPos(1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 12, 5);
        applyStimulus(0, 0, 0, 0);
        idle(3);
        applyStimulus(1, 1, 8, 2);
        applyStimulus(0, 0, 0, 0);
        idle(20);

        $display("[TB] async reset mid-period");
        applyStimulus(1, 1, 11, 6);
        idle(6);
        @(posedge clk_50M);
        #5;
        reset    = 1'b1;
        enable   = 1'b0;
        cfg_load = 1'b0;
        #1;
        checkOutput("async_clk_out", int'(clk_out), 0);
        checkOutput("async_tick", int'(period_tick), 0);
        checkOutput("async_pending", int'(cfg_pending), 0);
        modelReset();
        @(negedge clk_50M);
        reset = 1'b0;
        idle(20);

        $display("[TB] shrink 16 -> 4 loaded at cnt=12");
        waitPos(12);
        applyStimulus(1, 1, 4, 2);
        idle(20);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                          int'($urandom_range(0, 20)), int'($urandom_range(0, 24)));
        end

        @(posedge clk_50M);
        #2;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
